// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and constants for the adder sample datapath
package adder_pkg;

    localparam int SAMPLE_W = 5;
    localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = 5'd30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic logic [SAMPLE_W-1:0] sample_max(
        input logic [SAMPLE_W-1:0] a,
        input logic [SAMPLE_W-1:0] b
    );
        return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/adder_sum_accumulator.sv
// rtl/adder_sum_accumulator.sv - windowed sum/max accumulator over {C, Result} samples
module adder_sum_accumulator
    import adder_pkg::*;
#(
    parameter int COUNT = 8,
    parameter int SUM_W = 12
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [3:0]       Result,
    input  logic             C,
    input  logic             Clear,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [SUM_W-1:0] Sum,
    output logic [4:0]       Max
);

    generate
        if (COUNT < 2 || COUNT > 255) begin : g_bad_count
            $error("adder_sum_accumulator: COUNT must be in 2..255");
        end
        if (SUM_W < SAMPLE_W + $clog2(COUNT)) begin : g_bad_sum_w
            $error("adder_sum_accumulator: SUM_W too narrow for COUNT samples");
        end
    endgenerate

    localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [SUM_W-1:0]      r_acc;
    logic [SAMPLE_W-1:0]   r_max;
    logic [7:0]            r_cnt;
    logic [SUM_W-1:0]      r_sum;
    logic [SAMPLE_W-1:0]   r_max_out;

    logic [SAMPLE_W-1:0]   w_sample;
    logic [SUM_W-1:0]      w_acc_sum;
    logic [SAMPLE_W-1:0]   w_max_new;
    logic                  w_accept;
    logic                  w_deliver;
    logic                  w_last;

    assign w_sample  = {C, Result};
    assign w_acc_sum = r_acc + SUM_W'(w_sample);
    assign w_max_new = sample_max(r_max, w_sample);
    assign w_accept  = In_Valid & In_Ready;
    assign w_deliver = Out_Valid & Out_Ready;
    assign w_last    = (r_cnt == LAST_CNT);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clear outranks every handshake, so it is resolved before the state case.
    always_comb begin
        w_state_next = r_state;
        if (Clear) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) w_state_next = ACCUM;
                end
                ACCUM: begin
                    if (w_accept && w_last) w_state_next = HOLD;
                end
                HOLD: begin
                    if (w_deliver) w_state_next = IDLE;
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Handshake outputs depend only on registered state.
    always_comb begin
        In_Ready  = 1'b0;
        Out_Valid = 1'b0;
        case (r_state)
            IDLE:    In_Ready  = 1'b1;
            ACCUM:   In_Ready  = 1'b1;
            HOLD:    Out_Valid = 1'b1;
            default: In_Ready  = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_acc     <= '0;
            r_max     <= '0;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_max_out <= '0;
        end else if (Clear) begin
            r_acc <= '0;
            r_max <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (r_state == IDLE) begin
                r_acc <= SUM_W'(w_sample);
                r_max <= w_sample;
                r_cnt <= 8'd1;
            end else begin
                r_acc <= w_acc_sum;
                r_max <= w_max_new;
                r_cnt <= r_cnt + 8'd1;
                if (w_last) begin
                    r_sum     <= w_acc_sum;
                    r_max_out <= w_max_new;
                end
            end
        end
    end

    assign Sum = r_sum;
    assign Max = r_max_out;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// tb/tb_adder_sum_accumulator.sv - scoreboard bench for adder_sum_accumulator
module tb_adder_sum_accumulator;

    localparam int COUNT = 8;
    localparam int SUM_W = 12;

    logic             Clk;
    logic             Rst_n;
    logic             In_Valid;
    logic             In_Ready;
    logic [3:0]       Result;
    logic             C;
    logic             Clear;
    logic             Out_Valid;
    logic             Out_Ready;
    logic [SUM_W-1:0] Sum;
    logic [4:0]       Max;

    adder_sum_accumulator #(.COUNT(COUNT), .SUM_W(SUM_W)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Result    (Result),
        .C         (C),
        .Clear     (Clear),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Sum       (Sum),
        .Max       (Max)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks;
    int failures;
    logic [SUM_W+4:0] exp_q[$];
    logic [4:0] vec [COUNT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: every real deliver pops one expected window result.
    always @(negedge Clk) begin
        if (Rst_n && Out_Valid && Out_Ready && !Clear) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_deliver actual_sum=%0d actual_max=%0d expected=none", Sum, Max);
            end else begin
                logic [SUM_W+4:0] e;
                e = exp_q.pop_front();
                chk("sb_sum", 32'(Sum), 32'(e[SUM_W+4:5]));
                chk("sb_max", 32'(Max), 32'(e[4:0]));
            end
        end
    end

    task automatic idle_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [4:0] s);
        bit ok;
        ok = 1'b0;
        In_Valid = 1'b1;
        {C, Result} = s;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (In_Ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=In_Ready_low expected=accept");
        end
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
    endtask

    task automatic run_window(input bit gap, input bit push, input logic [SUM_W-1:0] es,
                              input logic [4:0] em);
        if (push) exp_q.push_back({es, em});
        for (int i = 0; i < COUNT; i++) begin
            if (i == COUNT - 1) chk("valid_before_last", 32'(Out_Valid), 0);
            send(vec[i]);
            if (gap && i < COUNT - 1) idle_cycle();
        end
        chk("valid_after_last", 32'(Out_Valid), 1);
        chk("ready_in_hold", 32'(In_Ready), 0);
    endtask

    task automatic deliver();
        Out_Ready = 1'b1;
        @(posedge Clk);
        #1;
        Out_Ready = 1'b0;
        chk("valid_after_deliver", 32'(Out_Valid), 0);
        chk("ready_after_deliver", 32'(In_Ready), 1);
    endtask

    task automatic fill(input logic [4:0] v);
        for (int i = 0; i < COUNT; i++) vec[i] = v;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        Rst_n = 1'b0;
        In_Valid = 1'b0;
        Result = 4'd0;
        C = 1'b0;
        Clear = 1'b0;
        Out_Ready = 1'b0;

        repeat (3) @(posedge Clk);
        #1;
        chk("rst_in_ready", 32'(In_Ready), 1);
        chk("rst_out_valid", 32'(Out_Valid), 0);
        chk("rst_sum", 32'(Sum), 0);
        chk("rst_max", 32'(Max), 0);
        Rst_n = 1'b1;
        repeat (3) idle_cycle();
        chk("post_rst_out_valid", 32'(Out_Valid), 0);
        chk("post_rst_in_ready", 32'(In_Ready), 1);

        // Nominal 1..8 back to back.
        for (int i = 0; i < COUNT; i++) vec[i] = 5'(i + 1);
        run_window(1'b0, 1'b1, 12'd36, 5'd8);
        deliver();

        // All-30 samples with a gap cycle between each.
        fill(5'd30);
        run_window(1'b1, 1'b1, 12'd240, 5'd30);
        deliver();

        fill(5'd0);
        run_window(1'b0, 1'b1, 12'd0, 5'd0);
        deliver();

        // Backpressure: window stays in HOLD while upstream keeps offering samples.
        vec = '{5'd3, 5'd1, 5'd4, 5'd1, 5'd5, 5'd9, 5'd2, 5'd6};
        run_window(1'b0, 1'b1, 12'd31, 5'd9);
        In_Valid = 1'b1;
        {C, Result} = 5'd30;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("bp_in_ready", 32'(In_Ready), 0);
            chk("bp_sum_stable", 32'(Sum), 31);
            chk("bp_max_stable", 32'(Max), 9);
        end
        @(posedge Clk);
        #1;
        deliver();
        In_Valid = 1'b0;
        fill(5'd1);
        run_window(1'b0, 1'b1, 12'd8, 5'd1);
        deliver();

        // Clear mid-window discards the partial sum.
        send(5'd5);
        send(5'd7);
        send(5'd9);
        Clear = 1'b1;
        idle_cycle();
        Clear = 1'b0;
        chk("clr_in_ready", 32'(In_Ready), 1);
        chk("clr_out_valid", 32'(Out_Valid), 0);
        fill(5'd2);
        run_window(1'b0, 1'b1, 12'd16, 5'd2);
        deliver();

        // Clear coincident with deliver: the result is dropped.
        vec = '{5'd7, 5'd3, 5'd7, 5'd1, 5'd0, 5'd7, 5'd2, 5'd4};
        run_window(1'b0, 1'b0, 12'd31, 5'd7);
        chk("hold_tie_max", 32'(Max), 7);
        chk("hold_sum", 32'(Sum), 31);
        Clear = 1'b1;
        Out_Ready = 1'b1;
        idle_cycle();
        Clear = 1'b0;
        Out_Ready = 1'b0;
        chk("clr_dlv_out_valid", 32'(Out_Valid), 0);
        chk("clr_dlv_in_ready", 32'(In_Ready), 1);

        // Async reset while in HOLD.
        fill(5'd5);
        run_window(1'b0, 1'b0, 12'd40, 5'd5);
        #1;
        Rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(Out_Valid), 0);
        chk("arst_in_ready", 32'(In_Ready), 1);
        chk("arst_sum", 32'(Sum), 0);
        chk("arst_max", 32'(Max), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        idle_cycle();
        for (int i = 0; i < COUNT; i++) vec[i] = 5'(COUNT - i);
        run_window(1'b0, 1'b1, 12'd36, 5'd8);
        deliver();

        repeat (2) idle_cycle();
        chk("sb_queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
